mesh_ctrl_nxn: RTL and testbench

- Control FSM for an N×N 2D-mesh (systolic) matrix-multiply array; generalises the fixed 2×2 mesh controller.
- Generates skewed row/column feed enables, per-PE accumulate enables, accumulator clear and per-PE result-capture enables for a runtime inner dimension KLEN.
- Adds BUSY/DONE handshake and ABORT. Sits between the host/sequencer and the mesh datapath registers.

---
 rtl/mesh_pkg.sv | 36 +++
 rtl/mesh_ctrl_nxn_skew.sv | 51 +++++
 rtl/mesh_ctrl_nxn.sv | 130 +++++++++++++
 tb/tb_mesh_ctrl_nxn.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for the N x N mesh controller.
//   state_t    : controller state encoding
//   clog2      : ceiling log2, usable in constant expressions
//   cnt_width  : RUN counter width for a given KLEN width and mesh size
//   idx        : flat PE index, PE(i,j) -> i*N+j
package mesh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Wide enough for (2^kw - 1) + 2(n-1), so the RUN counter never wraps.
    function automatic int cnt_width(input int kw, input int n);
        return kw + clog2(2 * n);
    endfunction

    function automatic int idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/mesh_ctrl_nxn_skew.sv
// mesh_skew_decode: combinational skew decoder for the systolic mesh.
// Ports:
//   t       in  CW    RUN cycle counter
//   kl      in  KW    latched inner dimension
//   run_vld in  1     controller is in RUN
//   en_row  out N     A feed enable per row, high for i <= t < i+kl
//   en_col  out N     B feed enable per column, high for j <= t < j+kl
//   en_pe   out N*N   accumulate enable, high for i+j <= t < i+j+kl
//   en_res  out N*N   result capture, high at t == i+j+kl
module mesh_skew_decode
    import mesh_pkg::*;
#(
    parameter int N  = 2,
    parameter int KW = 4,
    parameter int CW = 6
) (
    input  logic [CW-1:0]  t,
    input  logic [KW-1:0]  kl,
    input  logic           run_vld,
    output logic [N-1:0]   en_row,
    output logic [N-1:0]   en_col,
    output logic [N*N-1:0] en_pe,
    output logic [N*N-1:0] en_res
);

    // One spare bit so offset + kl cannot overflow.
    localparam int XW = CW + 1;

    logic [XW-1:0] tx;
    logic [XW-1:0] klx;

    assign tx  = {1'b0, t};
    assign klx = {{(XW-KW){1'b0}}, kl};

    // The window test off <= t < off+kl is written as (t - off) < kl:
    // when t < off the subtraction wraps to a value far above any kl.
    for (genvar i = 0; i < N; i++) begin : g_line
        localparam logic [XW-1:0] OFS = XW'(i);
        assign en_row[i] = run_vld && ((tx - OFS) < klx);
        assign en_col[i] = run_vld && ((tx - OFS) < klx);
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam logic [XW-1:0] OFS = XW'(i + j);
            assign en_pe[idx(i, j, N)]  = run_vld && ((tx - OFS) < klx);
            assign en_res[idx(i, j, N)] = run_vld && (tx == OFS + klx);
        end
    end

endmodule

// File: rtl/mesh_ctrl_nxn.sv
// mesh_ctrl_nxn: control FSM for an N x N systolic matrix-multiply mesh.
// Ports:
//   CLK, RST     clock (rising edge), async active-high reset
//   STM          start, accepted only in IDLE when ABORT is low
//   KLEN  [KW]   inner dimension, latched on accepted STM
//   ABORT        abort; forces all enables/CLR_PE/DONE low in its cycle
//   CLR_PE       accumulator clear (CLEAR state)
//   EN_ROW/EN_COL [N]   skewed operand feed enables
//   EN_PE/EN_RES  [N*N] accumulate / result-capture enables, bit i*N+j
//   BUSY, DONE, EOM     handshake: BUSY in CLEAR/RUN/DONE, DONE pulse, EOM in IDLE
module mesh_ctrl_nxn
    import mesh_pkg::*;
#(
    parameter int N  = 2,
    parameter int KW = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           STM,
    input  logic [KW-1:0]  KLEN,
    input  logic           ABORT,
    output logic           CLR_PE,
    output logic [N-1:0]   EN_ROW,
    output logic [N-1:0]   EN_COL,
    output logic [N*N-1:0] EN_PE,
    output logic [N*N-1:0] EN_RES,
    output logic           BUSY,
    output logic           DONE,
    output logic           EOM
);

    localparam int CW = cnt_width(KW, N);
    localparam logic [CW-1:0] SKEW = CW'(2 * (N - 1));

    state_t        state;
    logic [CW-1:0] t;
    logic [KW-1:0] kl;
    logic [CW-1:0] tl;
    logic          clr_q;
    logic          done_q;
    logic          busy_q;
    logic          eom_q;

    logic [N-1:0]   row_d;
    logic [N-1:0]   col_d;
    logic [N*N-1:0] pe_d;
    logic [N*N-1:0] res_d;

    assign tl = {{(CW-KW){1'b0}}, kl} + SKEW;

    // Flag registers are loaded with the decode of the state being entered,
    // so they always match the registered state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            t      <= '0;
            kl     <= '0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            eom_q  <= 1'b1;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (STM && !ABORT) begin
                        kl     <= KLEN;
                        state  <= ST_CLEAR;
                        clr_q  <= 1'b1;
                        busy_q <= 1'b1;
                        eom_q  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (ABORT) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        eom_q  <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                        t     <= '0;
                    end
                end
                ST_RUN: begin
                    if (ABORT) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        eom_q  <= 1'b1;
                    end else if (t == tl) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    eom_q  <= 1'b1;
                end
            endcase
        end
    end

    mesh_skew_decode #(
        .N  (N),
        .KW (KW),
        .CW (CW)
    ) u_skew (
        .t       (t),
        .kl      (kl),
        .run_vld (state == ST_RUN),
        .en_row  (row_d),
        .en_col  (col_d),
        .en_pe   (pe_d),
        .en_res  (res_d)
    );

    // ABORT suppresses anything that would commit state in the mesh this cycle.
    assign EN_ROW = row_d & {N{~ABORT}};
    assign EN_COL = col_d & {N{~ABORT}};
    assign EN_PE  = pe_d  & {(N*N){~ABORT}};
    assign EN_RES = res_d & {(N*N){~ABORT}};
    assign CLR_PE = clr_q  & ~ABORT;
    assign DONE   = done_q & ~ABORT;
    assign BUSY   = busy_q;
    assign EOM    = eom_q;

endmodule

// File: tb/tb_mesh_ctrl_nxn.sv
// Directed bench for mesh_ctrl_nxn: an N=2 and an N=4 instance share CLK/RST.
module tb_mesh_ctrl_nxn;

    logic CLK = 1'b0;
    logic RST;

    logic       stm2, abort2;
    logic [3:0] klen2;
    logic       clr2, busy2, done2, eom2;
    logic [1:0] row2, col2;
    logic [3:0] pe2, res2;

    logic        stm4, abort4;
    logic [3:0]  klen4;
    logic        clr4, busy4, done4, eom4;
    logic [3:0]  row4, col4;
    logic [15:0] pe4, res4;

    int n_checks = 0;
    int n_fail   = 0;
    int bc;

    // Hand-computed tables, index = t
    logic [3:0] pe_k2  [5] = '{4'b0001, 4'b0111, 4'b1110, 4'b1000, 4'b0000};
    logic [3:0] res_k2 [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0110, 4'b1000};
    logic [1:0] row_k2 [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [3:0] res_k0 [3] = '{4'b0001, 4'b0110, 4'b1000};
    logic [3:0] pe_k1  [4] = '{4'b0001, 4'b0110, 4'b1000, 4'b0000};
    logic [3:0] res_k1 [4] = '{4'b0000, 4'b0001, 4'b0110, 4'b1000};

    mesh_ctrl_nxn #(.N(2), .KW(4)) dut2 (
        .CLK(CLK), .RST(RST), .STM(stm2), .KLEN(klen2), .ABORT(abort2),
        .CLR_PE(clr2), .EN_ROW(row2), .EN_COL(col2), .EN_PE(pe2), .EN_RES(res2),
        .BUSY(busy2), .DONE(done2), .EOM(eom2)
    );

    mesh_ctrl_nxn #(.N(4), .KW(4)) dut4 (
        .CLK(CLK), .RST(RST), .STM(stm4), .KLEN(klen4), .ABORT(abort4),
        .CLR_PE(clr4), .EN_ROW(row4), .EN_COL(col4), .EN_PE(pe4), .EN_RES(res4),
        .BUSY(busy4), .DONE(done4), .EOM(eom4)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        stm2 = 1'b0; abort2 = 1'b0; klen2 = '0;
        stm4 = 1'b0; abort4 = 1'b0; klen4 = '0;
        #12;
        check("rst_eom",  eom2,  1);
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_clr",  clr2,  0);
        check("rst_pe",   pe2,   0);
        check("rst_res",  res2,  0);
        @(negedge CLK);
        RST = 1'b0;
        tick;
        check("idle_eom", eom2, 1);

        // N=2, KLEN=2, STM re-asserted with another KLEN during RUN
        stm2 = 1'b1; klen2 = 4'd2;
        tick;
        stm2 = 1'b0; klen2 = 4'd7;
        check("k2_clr",  clr2,  1);
        check("k2_busy", busy2, 1);
        check("k2_eom",  eom2,  0);
        for (int t = 0; t < 5; t++) begin
            tick;
            if (t == 1) begin stm2 = 1'b1; klen2 = 4'd5; end
            if (t == 3) stm2 = 1'b0;
            check("k2_pe",  pe2,  pe_k2[t]);
            check("k2_res", res2, res_k2[t]);
            check("k2_row", row2, row_k2[t]);
            check("k2_col", col2, row_k2[t]);
            check("k2_clr_run", clr2, 0);
        end
        tick;
        check("k2_done", done2, 1);
        check("k2_done_busy", busy2, 1);
        check("k2_done_pe", pe2, 0);
        check("k2_done_res", res2, 0);
        tick;
        check("k2_end_eom", eom2, 1);
        check("k2_end_done", done2, 0);
        check("k2_end_busy", busy2, 0);

        // N=2, KLEN=0
        stm2 = 1'b1; klen2 = 4'd0;
        tick;
        stm2 = 1'b0;
        check("k0_clr", clr2, 1);
        for (int t = 0; t < 3; t++) begin
            tick;
            check("k0_row", row2, 0);
            check("k0_col", col2, 0);
            check("k0_pe",  pe2,  0);
            check("k0_res", res2, res_k0[t]);
        end
        tick;
        check("k0_done", done2, 1);
        tick;
        check("k0_eom", eom2, 1);

        // ABORT at RUN t=2, then KLEN=1 run
        stm2 = 1'b1; klen2 = 4'd2;
        tick;
        stm2 = 1'b0;
        tick; tick; tick;
        check("ab_pre_pe",  pe2,  4'b1110);
        check("ab_pre_res", res2, 4'b0001);
        abort2 = 1'b1;
        #1;
        check("ab_pe",  pe2,  0);
        check("ab_res", res2, 0);
        check("ab_row", row2, 0);
        check("ab_col", col2, 0);
        tick;
        abort2 = 1'b0;
        check("ab_eom",  eom2,  1);
        check("ab_busy", busy2, 0);
        check("ab_done", done2, 0);
        stm2 = 1'b1; klen2 = 4'd1;
        tick;
        stm2 = 1'b0;
        check("k1_clr", clr2, 1);
        for (int t = 0; t < 4; t++) begin
            tick;
            check("k1_pe",  pe2,  pe_k1[t]);
            check("k1_res", res2, res_k1[t]);
        end
        tick;
        check("k1_done", done2, 1);
        tick;
        check("k1_eom", eom2, 1);

        // STM and ABORT together in IDLE
        stm2 = 1'b1; abort2 = 1'b1; klen2 = 4'd2;
        tick;
        check("sa_eom",  eom2,  1);
        check("sa_busy", busy2, 0);
        check("sa_clr",  clr2,  0);
        stm2 = 1'b0; abort2 = 1'b0;
        tick;
        check("sa_busy2", busy2, 0);

        // Async RST mid-RUN
        stm2 = 1'b1; klen2 = 4'd2;
        tick;
        stm2 = 1'b0;
        tick; tick;
        check("rr_pre_pe", pe2, 4'b0111);
        #2 RST = 1'b1;
        #1;
        check("rr_eom",  eom2,  1);
        check("rr_busy", busy2, 0);
        check("rr_pe",   pe2,   0);
        check("rr_row",  row2,  0);
        @(negedge CLK);
        RST = 1'b0;
        tick; tick;
        check("rr_idle_eom",  eom2,  1);
        check("rr_idle_busy", busy2, 0);

        // N=4, KLEN=3: TL = 9
        stm4 = 1'b1; klen4 = 4'd3;
        bc = 0;
        for (int c = 1; c <= 16; c++) begin
            tick;
            if (c == 1) stm4 = 1'b0;
            if (busy4) bc++;
            if (c >= 2 && c <= 11) begin
                check("n4_row3",  row4[3],  ((c - 2) >= 3 && (c - 2) <= 5));
                check("n4_pe15",  pe4[15],  ((c - 2) >= 6 && (c - 2) <= 8));
                check("n4_res15", res4[15], ((c - 2) == 9));
            end
            check("n4_done", done4, (c == 12));
        end
        check("n4_busy_cycles", bc, 12);
        check("n4_eom", eom4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
